// File: rtl/accu_result_fifo.sv
// Show-ahead result FIFO behind the 4-sample accumulator. It captures sums on valid_in
// and serves them over valid/ready. Pushes that arrive while full are dropped and flagged.
module accu_result_fifo #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 4,
    parameter int AVG_SHIFT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          ready_out,
    output logic                          valid_out,
    output logic [DATA_W-1:0]             data_out,
    output logic [DATA_W-AVG_SHIFT-1:0]   avg_out,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int AVG_W = DATA_W - AVG_SHIFT;

    // Floor average: plain truncation of the sum, no rounding term.
    function automatic logic [AVG_W-1:0] avg_of(input logic [DATA_W-1:0] sum);
        return AVG_W'(sum >> AVG_SHIFT);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_r;
    logic              overflow_r;

    logic push;
    logic pop;
    logic full;
    logic empty;
    logic accept;
    logic drop;

    assign push   = valid_in;
    assign empty  = (level_r == '0);
    assign full   = (level_r == LVL_W'(DEPTH));
    assign pop    = !empty && ready_out;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept && !pop)
                level_r <= level_r + LVL_W'(1);
            else if (pop && !accept)
                level_r <= level_r - LVL_W'(1);
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop)
                overflow_r <= 1'b1;
            else if (clr_ovf)
                overflow_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= data_in;
    end

    assign valid_out = !empty;
    assign data_out  = empty ? '0 : mem[rd_ptr];
    assign avg_out   = avg_of(data_out);
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_accu_result_fifo.sv
// Directed bench for accu_result_fifo. A queue model is checked on every falling edge,
// and literal expectations pin each test-plan scenario.
`timescale 1ns/100ps
module tb_accu_result_fifo;

    localparam int DATA_W    = 10;
    localparam int DEPTH     = 4;
    localparam int AVG_SHIFT = 2;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        valid_in = 1'b0;
    logic [DATA_W-1:0]           data_in = '0;
    logic                        ready_out = 1'b0;
    logic                        clr_ovf = 1'b0;
    logic                        valid_out;
    logic [DATA_W-1:0]           data_out;
    logic [DATA_W-AVG_SHIFT-1:0] avg_out;
    logic [$clog2(DEPTH):0]      level;
    logic                        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    accu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AVG_SHIFT(AVG_SHIFT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
        .avg_out(avg_out), .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of held sums plus the sticky flag.
    int q[$];
    bit m_ovf = 1'b0;

    always @(negedge rst) begin
        q.delete();
        m_ovf = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            bit m_pop;
            bit m_full;
            m_pop  = (q.size() > 0) && ready_out;
            m_full = (q.size() == DEPTH);
            if (m_pop)
                void'(q.pop_front());
            if (valid_in && (!m_full || m_pop))
                q.push_back(int'(data_in));
            if (valid_in && m_full && !m_pop)
                m_ovf = 1'b1;
            else if (clr_ovf)
                m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        int head;
        head = (q.size() > 0) ? q[0] : 0;
        check("model_valid", int'(valid_out), int'(q.size() > 0));
        check("model_data", int'(data_out), head);
        check("model_avg", int'(avg_out), head / 4);
        check("model_level", int'(level), q.size());
        check("model_ovf", int'(overflow), int'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_valid", int'(valid_out), 0);
        check("rst_level", int'(level), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_data", int'(data_out), 0);
        #9 rst = 1'b1;
        step();

        // Single pass
        ready_out = 1'b1; valid_in = 1'b1; data_in = 10'd400;
        step();
        valid_in = 1'b0;
        check("single_valid", int'(valid_out), 1);
        check("single_data", int'(data_out), 400);
        check("single_avg", int'(avg_out), 100);
        check("single_level", int'(level), 1);
        step();
        check("single_level_after_pop", int'(level), 0);
        check("single_valid_after_pop", int'(valid_out), 0);

        // Fill and overflow
        ready_out = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            valid_in = 1'b1; data_in = DATA_W'(v);
            step();
        end
        valid_in = 1'b0;
        check("fill_level", int'(level), 4);
        check("fill_head", int'(data_out), 1);
        valid_in = 1'b1; data_in = 10'd999;
        step();
        valid_in = 1'b0;
        check("ovf_set", int'(overflow), 1);
        check("ovf_level", int'(level), 4);
        check("ovf_head", int'(data_out), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clear", int'(overflow), 0);

        // Full with simultaneous pop
        ready_out = 1'b1; valid_in = 1'b1; data_in = 10'd7;
        step();
        valid_in = 1'b0; ready_out = 1'b0;
        check("fullpop_level", int'(level), 4);
        check("fullpop_ovf", int'(overflow), 0);
        ready_out = 1'b1;
        begin
            int exp_order[4] = '{2, 3, 4, 7};
            for (int i = 0; i < 4; i++) begin
                check("drain_order", int'(data_out), exp_order[i]);
                step();
            end
        end
        ready_out = 1'b0;
        check("drain_level", int'(level), 0);
        check("drain_data", int'(data_out), 0);

        // Drop together with clr_ovf: set wins
        for (int v = 11; v <= 14; v++) begin
            valid_in = 1'b1; data_in = DATA_W'(v);
            step();
        end
        data_in = 10'd15; clr_ovf = 1'b1;
        step();
        valid_in = 1'b0; clr_ovf = 1'b0;
        check("set_wins_ovf", int'(overflow), 1);
        check("set_wins_head", int'(data_out), 11);

        // Async reset with level 3
        ready_out = 1'b1;
        step();
        ready_out = 1'b0;
        check("pre_rst_level", int'(level), 3);
        #2 rst = 1'b0;
        #1;
        check("async_valid", int'(valid_out), 0);
        check("async_level", int'(level), 0);
        check("async_ovf", int'(overflow), 0);
        #3 rst = 1'b1;
        step();
        valid_in = 1'b1; data_in = 10'd55;
        step();
        valid_in = 1'b0;
        check("post_rst_valid", int'(valid_out), 1);
        check("post_rst_data", int'(data_out), 55);
        ready_out = 1'b1;
        step();

        // Wrap-around with streaming push/pop
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1; data_in = DATA_W'(i);
            step();
            check("wrap_data", int'(data_out), i);
            check("wrap_avg", int'(avg_out), i >> 2);
            check("wrap_level", int'(level), 1);
        end
        valid_in = 1'b0;
        step();
        check("wrap_end_level", int'(level), 0);
        ready_out = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
